// File: rtl/fp_mul_sched.sv
// Round-robin scheduler that shares one pipelined FP32 multiplier core among NREQ requesters.
// It registers the granted operands into the core and returns the result to the issuer with a one-hot strobe.
module fp_mul_sched #(
  parameter int NREQ    = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_X,
  input  logic [NREQ*32-1:0]   req_Y,
  input  logic [NREQ*3-1:0]    req_rmode,
  output logic                 mul_vld,
  output logic [31:0]          mul_X,
  output logic [31:0]          mul_Y,
  output logic [2:0]           mul_rmode,
  input  logic [31:0]          mul_Z,
  input  logic                 mul_ovrf,
  input  logic                 mul_udrf,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_Z,
  output logic                 rsp_ovrf,
  output logic                 rsp_udrf,
  output logic                 idle
);

  localparam int unsigned NR  = NREQ;
  localparam int          IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int          CW  = $clog2(MUL_LAT + 3);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] cand;
  logic           xfer;
  logic [31:0]    sel_x;
  logic [31:0]    sel_y;
  logic [2:0]     sel_rm;
  logic [MUL_LAT:0] tag_vld;
  logic [IDW-1:0] tag_id [MUL_LAT+1];
  logic [CW-1:0]  inflight;
  logic           rsp_any;

  always_comb begin
    xfer   = 1'b0;
    gnt_id = '0;
    cand   = '0;
    if (cfg_en) begin
      for (int unsigned i = 0; i < NR; i++) begin
        cand = IDW'((32'(rr_ptr) + i) % NR);
        if (!xfer && req_valid[cand]) begin
          xfer   = 1'b1;
          gnt_id = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    sel_x  = '0;
    sel_y  = '0;
    sel_rm = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_x  = req_X[32*i +: 32];
        sel_y  = req_Y[32*i +: 32];
        sel_rm = req_rmode[3*i +: 3];
      end
    end
  end

  assign rsp_any = |rsp_valid;
  assign idle    = (inflight == '0);

  // Tag stage 0 loads alongside the issue register, so stage MUL_LAT lines up with the core result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      mul_vld   <= 1'b0;
      mul_X     <= '0;
      mul_Y     <= '0;
      mul_rmode <= '0;
      tag_vld   <= '0;
      for (int unsigned k = 0; k <= MUL_LAT; k++) tag_id[k] <= '0;
      rsp_valid <= '0;
      rsp_Z     <= '0;
      rsp_ovrf  <= 1'b0;
      rsp_udrf  <= 1'b0;
      inflight  <= '0;
    end else begin
      mul_vld <= xfer;
      if (xfer) begin
        rr_ptr    <= (gnt_id == IDW'(NR - 1)) ? '0 : gnt_id + 1'b1;
        mul_X     <= sel_x;
        mul_Y     <= sel_y;
        mul_rmode <= sel_rm;
      end

      tag_vld[0] <= xfer;
      tag_id[0]  <= gnt_id;
      for (int unsigned k = 1; k <= MUL_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end

      rsp_valid <= '0;
      if (tag_vld[MUL_LAT]) begin
        rsp_valid[tag_id[MUL_LAT]] <= 1'b1;
        rsp_Z    <= mul_Z;
        rsp_ovrf <= mul_ovrf;
        rsp_udrf <= mul_udrf;
      end

      if (xfer && !rsp_any)
        inflight <= inflight + 1'b1;
      else if (!xfer && rsp_any)
        inflight <= inflight - 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed bench for fp_mul_sched: a MUL_LAT=3 instance and a MUL_LAT=0 instance,
// each fed by a small behavioural core with a lookup for the FP products used.
module tb_fp_mul_sched;

  logic        clk;
  logic        rst;
  int          total;
  int          bad;

  logic        cfg_en;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_X;
  logic [63:0] req_Y;
  logic [5:0]  req_rmode;
  logic        mul_vld;
  logic [31:0] mul_X;
  logic [31:0] mul_Y;
  logic [2:0]  mul_rmode;
  logic [31:0] mul_Z;
  logic        mul_ovrf;
  logic        mul_udrf;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_Z;
  logic        rsp_ovrf;
  logic        rsp_udrf;
  logic        idle;

  logic        z_cfg_en;
  logic [1:0]  z_req_valid;
  logic [1:0]  z_req_ready;
  logic [63:0] z_req_X;
  logic [63:0] z_req_Y;
  logic [5:0]  z_req_rmode;
  logic        z_mul_vld;
  logic [31:0] z_mul_X;
  logic [31:0] z_mul_Y;
  logic [2:0]  z_mul_rmode;
  logic [31:0] z_mul_Z;
  logic        z_mul_ovrf;
  logic        z_mul_udrf;
  logic [1:0]  z_rsp_valid;
  logic [31:0] z_rsp_Z;
  logic        z_rsp_ovrf;
  logic        z_rsp_udrf;
  logic        z_idle;

  logic [33:0] p1, p2, p3;

  fp_mul_sched #(.NREQ(2), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_X(req_X), .req_Y(req_Y), .req_rmode(req_rmode),
    .mul_vld(mul_vld), .mul_X(mul_X), .mul_Y(mul_Y), .mul_rmode(mul_rmode),
    .mul_Z(mul_Z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
    .rsp_valid(rsp_valid), .rsp_Z(rsp_Z), .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf),
    .idle(idle)
  );

  fp_mul_sched #(.NREQ(2), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .cfg_en(z_cfg_en),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_X(z_req_X), .req_Y(z_req_Y), .req_rmode(z_req_rmode),
    .mul_vld(z_mul_vld), .mul_X(z_mul_X), .mul_Y(z_mul_Y), .mul_rmode(z_mul_rmode),
    .mul_Z(z_mul_Z), .mul_ovrf(z_mul_ovrf), .mul_udrf(z_mul_udrf),
    .rsp_valid(z_rsp_valid), .rsp_Z(z_rsp_Z), .rsp_ovrf(z_rsp_ovrf), .rsp_udrf(z_rsp_udrf),
    .idle(z_idle)
  );

  // Returns {ovrf, udrf, Z}; non-table operands give X^Y with sign bits as flags.
  function automatic logic [33:0] core_f(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h40000000 && y == 32'h40400000) return {2'b00, 32'h40C00000};
    if (x == 32'h3FC00000 && y == 32'h3FC00000) return {2'b00, 32'h40100000};
    return {x[31], y[31], x ^ y};
  endfunction

  always @(posedge clk) begin
    p1 <= core_f(mul_X, mul_Y);
    p2 <= p1;
    p3 <= p2;
  end
  assign {mul_ovrf, mul_udrf, mul_Z} = p3;
  assign {z_mul_ovrf, z_mul_udrf, z_mul_Z} = core_f(z_mul_X, z_mul_Y);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    total++; if ({mul_vld, mul_X, mul_Y, mul_rmode} !== 68'd0) begin bad++; $display("FAIL reset_mul got=%b %h %h %b exp=0", mul_vld, mul_X, mul_Y, mul_rmode); end
    total++; if ({rsp_valid, rsp_Z, rsp_ovrf, rsp_udrf} !== 36'd0) begin bad++; $display("FAIL reset_rsp got=%b %h %b %b exp=0", rsp_valid, rsp_Z, rsp_ovrf, rsp_udrf); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
    total++; if ({z_idle, z_mul_vld, z_rsp_valid} !== 4'b1000) begin bad++; $display("FAIL reset_lat0 got=%b exp=1000", {z_idle, z_mul_vld, z_rsp_valid}); end
  endtask

  task automatic test_single();
    req_valid = 2'b01;
    req_X = {32'hDEADBEEF, 32'h40000000};
    req_Y = {32'hCAFEF00D, 32'h40400000};
    req_rmode = 6'b100_000;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    total++; if ({mul_vld, mul_X, mul_Y, mul_rmode} !== {1'b1, 32'h40000000, 32'h40400000, 3'b000}) begin
      bad++; $display("FAIL single_issue got=%b %h %h %b exp=1 40000000 40400000 000", mul_vld, mul_X, mul_Y, mul_rmode);
    end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", idle); end
    for (int k = 2; k <= 4; k++) begin
      tick(); #1;
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL single_early k=%0d got=%b exp=00", k, rsp_valid); end
      if (k == 2) begin
        total++; if ({mul_vld, mul_X} !== {1'b0, 32'h40000000}) begin bad++; $display("FAIL single_hold got=%b %h exp=0 40000000", mul_vld, mul_X); end
      end
    end
    tick(); #1;
    total++; if ({rsp_valid, rsp_Z, rsp_ovrf, rsp_udrf} !== {2'b01, 32'h40C00000, 2'b00}) begin
      bad++; $display("FAIL single_rsp got=%b %h %b%b exp=01 40c00000 00", rsp_valid, rsp_Z, rsp_ovrf, rsp_udrf);
    end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_idle_rsp got=%b exp=0", idle); end
    tick(); #1;
    total++; if ({rsp_valid, rsp_Z, idle} !== {2'b00, 32'h40C00000, 1'b1}) begin
      bad++; $display("FAIL single_after got=%b %h %b exp=00 40c00000 1", rsp_valid, rsp_Z, idle);
    end
  endtask

  task automatic test_contention();
    int cnt0, cnt1;
    logic [1:0]  e_v;
    logic [33:0] e_r;
    cnt0 = 0; cnt1 = 0;
    do_reset();
    req_X = {32'h00000010, 32'h80000001};
    req_Y = {32'h80000100, 32'h00000003};
    req_rmode = 6'b100_001;
    req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      if (k == 4) req_valid = 2'b00;
      #1;
      if (k < 4) begin
        e_v = (k % 2 == 0) ? 2'b01 : 2'b10;
        total++; if (req_ready !== e_v) begin bad++; $display("FAIL cont_ready k=%0d got=%b exp=%b", k, req_ready, e_v); end
      end
      if (k >= 1 && k <= 4) begin
        total++; if (mul_rmode !== (((k - 1) % 2 == 0) ? 3'b001 : 3'b100)) begin bad++; $display("FAIL cont_rmode k=%0d got=%b", k, mul_rmode); end
      end
      if (k >= 5 && k <= 8) begin
        e_v = ((k - 5) % 2 == 0) ? 2'b01 : 2'b10;
        e_r = ((k - 5) % 2 == 0) ? {2'b10, 32'h80000002} : {2'b01, 32'h80000110};
        total++; if ({rsp_valid, rsp_ovrf, rsp_udrf, rsp_Z} !== {e_v, e_r}) begin
          bad++; $display("FAIL cont_rsp k=%0d got=%b %b%b %h exp=%b %h", k, rsp_valid, rsp_ovrf, rsp_udrf, rsp_Z, e_v, e_r);
        end
      end else if (k >= 1) begin
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL cont_quiet k=%0d got=%b exp=00", k, rsp_valid); end
      end
      if (rsp_valid[0]) cnt0++;
      if (rsp_valid[1]) cnt1++;
      tick();
    end
    total++; if (cnt0 != 2 || cnt1 != 2) begin bad++; $display("FAIL cont_count got=%0d,%0d exp=2,2", cnt0, cnt1); end
  endtask

  task automatic test_back_to_back();
    int peak;
    peak = 0;
    req_X = {32'h3FC00000, 32'h0};
    req_Y = {32'h3FC00000, 32'h0};
    req_rmode = 6'b011_000;
    req_valid = 2'b10;
    for (int k = 0; k < 14; k++) begin
      if (k == 8) req_valid = 2'b00;
      #1;
      if (int'(dut.inflight) > peak) peak = int'(dut.inflight);
      if (k < 8) begin
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=10", k, req_ready); end
      end
      if (k == 1) begin
        total++; if ({mul_X, mul_rmode} !== {32'h3FC00000, 3'b011}) begin bad++; $display("FAIL b2b_issue got=%h %b exp=3fc00000 011", mul_X, mul_rmode); end
      end
      if (k >= 5 && k <= 12) begin
        total++; if ({rsp_valid, rsp_Z} !== {2'b10, 32'h40100000}) begin bad++; $display("FAIL b2b_rsp k=%0d got=%b %h exp=10 40100000", k, rsp_valid, rsp_Z); end
      end else if (k >= 1) begin
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL b2b_quiet k=%0d got=%b exp=00", k, rsp_valid); end
      end
      if (k == 12) begin
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", idle); end
      end
      if (k == 13) begin
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", idle); end
      end
      tick();
    end
    total++; if (peak != 5) begin bad++; $display("FAIL b2b_peak got=%0d exp=5", peak); end
  endtask

  task automatic test_cfg_drop();
    int pulses;
    pulses = 0;
    do_reset();
    req_X = {32'h0, 32'h00000005};
    req_Y = {32'h0, 32'h00000006};
    req_rmode = 6'b000_000;
    req_valid = 2'b01;
    for (int k = 0; k < 13; k++) begin
      if (k == 2) cfg_en = 1'b0;
      if (k == 7) req_valid = 2'b00;
      #1;
      if (k < 2) begin
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL drop_ready_on k=%0d got=%b exp=01", k, req_ready); end
      end else if (k < 7) begin
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL drop_ready_off k=%0d got=%b exp=00", k, req_ready); end
      end
      if (k == 3) begin
        total++; if (mul_vld !== 1'b0) begin bad++; $display("FAIL drop_mul_vld got=%b exp=0", mul_vld); end
      end
      if (k == 5 || k == 6) begin
        total++; if ({rsp_valid, rsp_Z} !== {2'b01, 32'h00000003}) begin bad++; $display("FAIL drop_rsp k=%0d got=%b %h exp=01 00000003", k, rsp_valid, rsp_Z); end
      end
      if (rsp_valid != 2'b00) pulses++;
      tick();
    end
    total++; if (pulses != 2) begin bad++; $display("FAIL drop_count got=%0d exp=2", pulses); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL drop_idle got=%b exp=1", idle); end
    cfg_en = 1'b1;
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL drop_resume got=%b exp=10", req_ready); end
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 7; k++) tick();
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    do_reset();
    req_X = {32'h0, 32'h00000007};
    req_Y = {32'h0, 32'h00000009};
    req_valid = 2'b01;
    tick(); tick(); tick();
    req_valid = 2'b00;
    #1;
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", idle); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if ({mul_vld, idle} !== 2'b01) begin bad++; $display("FAIL mid_cleared got=%b exp=01", {mul_vld, idle}); end
    for (int k = 0; k < 7; k++) begin
      if (rsp_valid != 2'b00) seen++;
      tick(); #1;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_rsp got=%0d exp=0", seen); end
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_ptr got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 7; k++) tick();
  endtask

  task automatic test_lat0();
    z_req_X = {32'h40000000, 32'h0};
    z_req_Y = {32'h40400000, 32'h0};
    z_req_rmode = 6'b010_000;
    z_req_valid = 2'b10;
    #1;
    total++; if (z_req_ready !== 2'b10) begin bad++; $display("FAIL lat0_ready got=%b exp=10", z_req_ready); end
    tick();
    z_req_valid = 2'b00;
    #1;
    total++; if ({z_mul_vld, z_mul_rmode, z_rsp_valid} !== {1'b1, 3'b010, 2'b00}) begin
      bad++; $display("FAIL lat0_issue got=%b %b %b exp=1 010 00", z_mul_vld, z_mul_rmode, z_rsp_valid);
    end
    tick(); #1;
    total++; if ({z_rsp_valid, z_rsp_Z} !== {2'b10, 32'h40C00000}) begin bad++; $display("FAIL lat0_rsp got=%b %h exp=10 40c00000", z_rsp_valid, z_rsp_Z); end
    tick(); #1;
    total++; if ({z_rsp_valid, z_idle} !== 3'b001) begin bad++; $display("FAIL lat0_after got=%b %b exp=00 1", z_rsp_valid, z_idle); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0;
    cfg_en = 1'b1; req_valid = '0; req_X = '0; req_Y = '0; req_rmode = '0;
    z_cfg_en = 1'b1; z_req_valid = '0; z_req_X = '0; z_req_Y = '0; z_req_rmode = '0;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_cfg_drop();
    test_reset_midflight();
    test_lat0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
